ccff_bitstream_loader: RTL and testbench

CCFF_BITSTREAM_LOADER -- requirements
Module: ccff_bitstream_loader

---
 rtl/ccff_bitstream_loader.sv | 114 +++++++++++
 tb/tb_ccff_bitstream_loader.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ccff_bitstream_loader.sv
// Serialises a byte stream MSB-first into a ccff configuration chain and
// accumulates the parity of the bits that emerge from the chain tail.
//
//   state        | meaning
//   ST_IDLE      | waiting for start
//   ST_WAIT_BYTE | byte_ready high, waiting for the next bitstream byte
//   ST_SHIFT     | one bit per cycle into the chain head
//   ST_DONE      | one-cycle done pulse, then back to idle
module ccff_bitstream_loader #(
   parameter int CHAIN_LEN = 64,
   parameter int CNT_W     = 16
) (
   input  logic       prog_clk,
   input  logic       prog_reset,
   input  logic       start,
   input  logic       abort,
   input  logic [7:0] byte_data,
   input  logic       byte_valid,
   output logic       byte_ready,
   output logic       ccff_head,
   input  logic       ccff_tail,
   output logic       shift_en,
   output logic       busy,
   output logic       done,
   output logic       tail_parity
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT_BYTE,
      ST_SHIFT,
      ST_DONE
   } state_t;

   // Counter value during the shift that completes the chain.
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CHAIN_LEN - 1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
   logic [2:0]       idx_q, idx_d;
   logic [7:0]       sr_q, sr_d;
   logic             par_q, par_d;

   always_ff @(posedge prog_clk) begin
      if (prog_reset) begin
         state_q   <= ST_IDLE;
         bit_cnt_q <= '0;
         idx_q     <= '0;
         sr_q      <= '0;
         par_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         bit_cnt_q <= bit_cnt_d;
         idx_q     <= idx_d;
         sr_q      <= sr_d;
         par_q     <= par_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      idx_d     = idx_q;
      sr_d      = sr_q;
      par_d     = par_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               bit_cnt_d = '0;
               par_d     = 1'b0;
               state_d   = ST_WAIT_BYTE;
            end
         end
         ST_WAIT_BYTE: begin
            if (abort) begin
               state_d = ST_IDLE;
            end else if (byte_valid) begin
               sr_d    = byte_data;
               idx_d   = '0;
               state_d = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            sr_d      = {sr_q[6:0], 1'b0};
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
            idx_d     = idx_q + 3'd1;
            par_d     = par_q ^ ccff_tail;
            // Chain-full wins over end-of-byte: leftover low bits are dropped.
            if (abort) begin
               state_d = ST_IDLE;
            end else if (bit_cnt_q == LAST_CNT) begin
               state_d = ST_DONE;
            end else if (idx_q == 3'd7) begin
               state_d = ST_WAIT_BYTE;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Gated by reset so the chain does not advance on the edge that resets us.
   assign byte_ready  = !prog_reset && (state_q == ST_WAIT_BYTE);
   assign shift_en    = !prog_reset && (state_q == ST_SHIFT);
   assign ccff_head   = !prog_reset && (state_q == ST_SHIFT) && sr_q[7];
   assign busy        = !prog_reset && (state_q != ST_IDLE);
   assign done        = !prog_reset && (state_q == ST_DONE);
   assign tail_parity = par_q;

endmodule

// File: tb/tb_ccff_bitstream_loader.sv
// Bench for ccff_bitstream_loader: a 12-bit chain instance driven by a vector
// table, hand sequences and random loads, plus a 1-bit chain instance.
module tb_ccff_bitstream_loader;

   logic       prog_clk;
   logic       prog_reset;
   logic       start, b_start;
   logic       abort;
   logic [7:0] byte_data;
   logic       byte_valid;
   logic       ccff_tail;

   logic a_byte_ready, a_ccff_head, a_shift_en, a_busy, a_done, a_tail_parity;
   logic b_byte_ready, b_ccff_head, b_shift_en, b_busy, b_done, b_tail_parity;

   int n_vec = 0;
   int n_err = 0;

   ccff_bitstream_loader #(.CHAIN_LEN(12), .CNT_W(16)) dut_a (
      .prog_clk    (prog_clk),
      .prog_reset  (prog_reset),
      .start       (start),
      .abort       (abort),
      .byte_data   (byte_data),
      .byte_valid  (byte_valid),
      .byte_ready  (a_byte_ready),
      .ccff_head   (a_ccff_head),
      .ccff_tail   (ccff_tail),
      .shift_en    (a_shift_en),
      .busy        (a_busy),
      .done        (a_done),
      .tail_parity (a_tail_parity)
   );

   ccff_bitstream_loader #(.CHAIN_LEN(1), .CNT_W(16)) dut_b (
      .prog_clk    (prog_clk),
      .prog_reset  (prog_reset),
      .start       (b_start),
      .abort       (abort),
      .byte_data   (byte_data),
      .byte_valid  (byte_valid),
      .byte_ready  (b_byte_ready),
      .ccff_head   (b_ccff_head),
      .ccff_tail   (ccff_tail),
      .shift_en    (b_shift_en),
      .busy        (b_busy),
      .done        (b_done),
      .tail_parity (b_tail_parity)
   );

   initial prog_clk = 1'b0;
   always #5 prog_clk = ~prog_clk;

   // e = {busy, byte_ready, shift_en, ccff_head, done, tail_parity}
   typedef struct {
      logic       st;
      logic       ab;
      logic       vl;
      logic [7:0] d;
      logic       tl;
      logic [5:0] e;
   } vec_t;

   vec_t tbl[22];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, wanted %0h", nm, act, exp);
      end
   endtask

   task automatic drv(input logic st, input logic ab, input logic vl,
                      input logic [7:0] d, input logic tl);
      start      = st;
      abort      = ab;
      byte_valid = vl;
      byte_data  = d;
      ccff_tail  = tl;
      @(negedge prog_clk);
   endtask

   function automatic logic [5:0] a_outs();
      return {a_busy, a_byte_ready, a_shift_en, a_ccff_head, a_done, a_tail_parity};
   endfunction

   // Reference: the chain must receive the first 12 bits of {b0,b1} MSB-first,
   // and tail_parity is the XOR of the tail bits present on shifting edges.
   task automatic do_load(input logic [7:0] b0, input logic [7:0] b1,
                          input int stall0, input int stall1);
      logic [15:0] stream;
      int   nsh, ndone, run, stall, bi;
      logic par, pend, fin;
      stream = {b0, b1};
      nsh = 0; ndone = 0; run = 0; bi = 0;
      par = 1'b0; pend = 1'b0; fin = 1'b0;
      stall = stall0;
      abort = 1'b0; byte_valid = 1'b0; ccff_tail = 1'b0;
      start = 1'b1;
      @(negedge prog_clk);
      start = 1'b0;
      for (int cyc = 0; cyc < 150 && !fin; cyc++) begin
         if (a_shift_en) begin
            chk("shift_in_budget", 32'(nsh < 12), 1);
            if (nsh < 12) chk("head_bit", a_ccff_head, stream[15-nsh]);
            nsh++;
            run++;
            chk("bubble_per_byte", 32'(run <= 8), 1);
         end else begin
            run = 0;
            chk("head_low_no_shift", a_ccff_head, 0);
         end
         if (a_done) ndone++;
         if (ndone > 0 && !a_busy) begin
            fin = 1'b1;
         end else begin
            if (pend) begin
               bi++;
               stall = stall1;
            end
            if (bi < 2) begin
               if (stall > 0) begin
                  byte_valid = 1'b0;
                  if (a_byte_ready) stall--;
               end else begin
                  byte_valid = 1'b1;
                  byte_data  = (bi == 0) ? b0 : b1;
               end
            end else begin
               byte_valid = 1'b0;
            end
            pend      = byte_valid & a_byte_ready;
            start     = (cyc == 3);
            ccff_tail = 1'($urandom_range(0, 1));
            if (a_shift_en) par ^= ccff_tail;
            @(negedge prog_clk);
         end
      end
      start = 1'b0; byte_valid = 1'b0; ccff_tail = 1'b0;
      chk("load_finished", fin, 1);
      chk("shift_count", nsh, 12);
      chk("done_count", ndone, 1);
      chk("tail_parity", a_tail_parity, par);
   endtask

   initial begin
      tbl[0]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 6'b110000};
      tbl[1]  = '{1'b0, 1'b0, 1'b1, 8'hA5, 1'b0, 6'b101100};
      tbl[2]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 6'b101001};
      tbl[3]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 6'b101101};
      tbl[4]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 6'b101000};
      tbl[5]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 6'b101001};
      tbl[6]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 6'b101101};
      tbl[7]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 6'b101001};
      tbl[8]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 6'b101101};
      tbl[9]  = '{1'b0, 1'b0, 1'b1, 8'h3C, 1'b0, 6'b110001};
      tbl[10] = '{1'b0, 1'b0, 1'b1, 8'h3C, 1'b1, 6'b101001};
      tbl[11] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 6'b101000};
      tbl[12] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 6'b101100};
      tbl[13] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 6'b101100};
      tbl[14] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 6'b100011};
      tbl[15] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 6'b000001};
      tbl[16] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 6'b000001};
      tbl[17] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 6'b110000};
      tbl[18] = '{1'b0, 1'b1, 1'b1, 8'hA5, 1'b0, 6'b000000};
      tbl[19] = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 6'b110000};
      tbl[20] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 6'b110000};
      tbl[21] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 6'b000000};

      prog_reset = 1'b1;
      start = 1'b0; b_start = 1'b0; abort = 1'b0;
      byte_valid = 1'b0; byte_data = 8'h00; ccff_tail = 1'b0;
      @(negedge prog_clk);
      @(negedge prog_clk);
      chk("reset_outs_a", a_outs(), 6'b000000);
      chk("reset_outs_b", {b_busy, b_byte_ready, b_shift_en, b_ccff_head, b_done, b_tail_parity}, 6'b000000);
      prog_reset = 1'b0;
      @(negedge prog_clk);

      // A5,3C with no stall; five tail ones on shifting edges; abort cases.
      for (int i = 0; i < 22; i++) begin
         drv(tbl[i].st, tbl[i].ab, tbl[i].vl, tbl[i].d, tbl[i].tl);
         chk($sformatf("row%0d", i), a_outs(), tbl[i].e);
      end

      do_load(8'hA5, 8'h3C, 10, 0);
      do_load(8'hFF, 8'h81, 0, 3);

      // abort during the third shift cycle
      drv(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
      drv(1'b0, 1'b0, 1'b1, 8'hA5, 1'b0);
      drv(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
      drv(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
      chk("abort_pre_third_shift", {a_shift_en, a_ccff_head}, 2'b11);
      drv(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
      chk("abort_to_idle", a_outs() & 6'b111110, 6'b000000);
      drv(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
      chk("abort_no_done", {a_busy, a_done}, 2'b00);
      do_load(8'($urandom), 8'($urandom), 1, 1);

      // one-cycle reset in the middle of a shift
      drv(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
      drv(1'b0, 1'b0, 1'b1, 8'h3C, 1'b0);
      drv(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
      chk("pre_reset_shifting", a_shift_en, 1);
      prog_reset = 1'b1;
      #1;
      chk("reset_comb_outs", a_outs() & 6'b111110, 6'b000000);
      @(negedge prog_clk);
      chk("reset_outs_mid", a_outs(), 6'b000000);
      prog_reset = 1'b0;
      @(negedge prog_clk);
      chk("post_reset_idle", a_outs(), 6'b000000);
      do_load(8'($urandom), 8'($urandom), 0, 0);

      // 1-bit chain
      b_start = 1'b1; byte_valid = 1'b1; byte_data = 8'h80;
      @(negedge prog_clk);
      b_start = 1'b0;
      chk("b_wait", {b_busy, b_byte_ready}, 2'b11);
      @(negedge prog_clk);
      chk("b_shift_80", {b_shift_en, b_ccff_head, b_done}, 3'b110);
      byte_valid = 1'b0;
      @(negedge prog_clk);
      chk("b_done_80", {b_shift_en, b_done, b_busy}, 3'b011);
      @(negedge prog_clk);
      chk("b_idle_80", {b_busy, b_done}, 2'b00);
      b_start = 1'b1; byte_valid = 1'b1; byte_data = 8'h7F;
      @(negedge prog_clk);
      b_start = 1'b0;
      @(negedge prog_clk);
      chk("b_shift_7f", {b_shift_en, b_ccff_head}, 2'b10);
      byte_valid = 1'b0;
      @(negedge prog_clk);
      chk("b_done_7f", {b_shift_en, b_done}, 2'b01);
      @(negedge prog_clk);

      for (int k = 0; k < 40; k++) begin
         do_load(8'($urandom), 8'($urandom), $urandom_range(0, 4), $urandom_range(0, 4));
         @(negedge prog_clk);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
